// File: rtl/sram_mult_pkg.sv
// Shared constants and cycle classification for the weight-stationary SRAM multiply block.
// The coefficient SRAM, its pointers and the multiplier all use these constants.
package sram_mult_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_COUNT = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int MULT_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_LOAD,
        CYC_COMPUTE
    } cycle_kind_e;

    // Only a load before lock-in or a compute after lock-in does anything; every other combination idles.
    function automatic cycle_kind_e decode_cycle(input logic pe_ce,
                                                 input logic init_enable,
                                                 input logic init_done);
        if (!pe_ce) begin
            return CYC_IDLE;
        end
        if (init_enable && !init_done) begin
            return CYC_LOAD;
        end
        if (!init_enable && init_done) begin
            return CYC_COMPUTE;
        end
        return CYC_IDLE;
    endfunction

endpackage

// File: rtl/sram_16x8.sv
// Coefficient store: register array with one synchronous write port and one combinational read port.
// Contents are deliberately not reset; a reload after reset simply overwrites them.
module sram_16x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_COUNT = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ADDR_COUNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_mult_system.sv
// Weight-stationary multiply PE: loads ADDR_COUNT coefficients, then multiplies each streamed
// operand by the coefficients in rotating address order with a registered product.
module sram_mult_system #(
    parameter int DATA_WIDTH = sram_mult_pkg::DATA_WIDTH,
    parameter int ADDR_COUNT = sram_mult_pkg::ADDR_COUNT,
    parameter int ADDR_WIDTH = sram_mult_pkg::ADDR_WIDTH,
    parameter int MULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_ce,
    input  logic                  init_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [MULT_WIDTH-1:0] data_out,
    output logic                  init_done,
    output logic                  valid_out
);

    import sram_mult_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

    cycle_kind_e           cycle_kind;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] coef;
    logic [MULT_WIDTH-1:0] product;

    assign cycle_kind = decode_cycle(pe_ce, init_enable, init_done);
    assign mem_we     = (cycle_kind == CYC_LOAD);
    assign product    = MULT_WIDTH'(data_in) * MULT_WIDTH'(coef);

    sram_16x8 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_COUNT (ADDR_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (coef)
    );

    // The write pointer returns to 0 once the last word locks the coefficients in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            init_done <= 1'b0;
        end else if (cycle_kind == CYC_LOAD) begin
            if (wr_ptr == LAST_ADDR) begin
                wr_ptr    <= '0;
                init_done <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // The read pointer only advances on products, so gaps never re-align the address sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (cycle_kind == CYC_COMPUTE) begin
            data_out  <= product;
            valid_out <= 1'b1;
            rd_ptr    <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_mult_system.sv
// Directed bench for sram_mult_system: a reference model pushes expected products to a queue
// as operands are driven, and a monitor pops and compares them one edge later.
module tb_sram_mult_system;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pe_ce;
    logic        init_enable;
    logic [7:0]  data_in;
    logic [15:0] data_out;
    logic        init_done;
    logic        valid_out;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0]  coef [16];
    int          mdl_wr;
    int          mdl_rd;
    bit          mdl_done;
    bit          exp_valid;
    logic [15:0] last_data;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    sram_mult_system dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_ce       (pe_ce),
        .init_enable (init_enable),
        .data_in     (data_in),
        .data_out    (data_out),
        .init_done   (init_done),
        .valid_out   (valid_out)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at 2 time units after an edge; drives one cycle, updates the model, returns after the next edge.
    task automatic apply_stimulus(input bit pe, input bit ie, input logic [7:0] d);
        bit do_load;
        bit do_comp;
        pe_ce       = pe;
        init_enable = ie;
        data_in     = d;
        do_load = pe && ie && !mdl_done;
        do_comp = pe && !ie && mdl_done;
        if (do_load) begin
            coef[mdl_wr] = d;
            if (mdl_wr == 15) begin
                mdl_done = 1'b1;
                mdl_wr   = 0;
            end else begin
                mdl_wr++;
            end
        end
        if (do_comp) begin
            exp_q.push_back(16'(d) * 16'(coef[mdl_rd]));
            mdl_rd = (mdl_rd + 1) % 16;
        end
        exp_valid = do_comp;
        @(posedge clk);
        #2;
    endtask

    // Asserts reset in the middle of a cycle and checks that the outputs clear without waiting for an edge.
    task automatic apply_reset();
        #3;
        pe_ce       = 1'b0;
        init_enable = 1'b0;
        data_in     = '0;
        rst_n       = 1'b0;
        mdl_wr      = 0;
        mdl_rd      = 0;
        mdl_done    = 1'b0;
        exp_valid   = 1'b0;
        last_data   = '0;
        exp_q.delete();
        #1;
        check_output("reset_data_out", data_out, 16'h0000);
        check_output("reset_valid_out", valid_out, 1'b0);
        check_output("reset_init_done", init_done, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_words(input int first, input int count, input logic [7:0] base, input logic [7:0] step);
        for (int i = first; i < first + count; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'(base + 8'(i) * step));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_valid) begin
                check_output("valid_strobe", valid_out, 1'b1);
                last_data = exp_q.pop_front();
                check_output("product", data_out, last_data);
            end else begin
                check_output("idle_valid_low", valid_out, 1'b0);
                check_output("idle_data_hold", data_out, last_data);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        pe_ce       = 1'b0;
        init_enable = 1'b0;
        data_in     = '0;
        mdl_wr      = 0;
        mdl_rd      = 0;
        mdl_done    = 1'b0;
        exp_valid   = 1'b0;
        last_data   = '0;
        @(posedge clk);
        #2;
        apply_reset();

        // Load 1..16, operand 2 streamed with a pe_ce gap and an ignored late write.
        apply_stimulus(1'b0, 1'b1, 8'h77);
        load_words(0, 15, 8'd1, 8'd1);
        check_output("init_done_after_15", init_done, 1'b0);
        load_words(15, 1, 8'd1, 8'd1);
        check_output("init_done_after_16", init_done, 1'b1);
        apply_stimulus(1'b1, 1'b0, 8'd2);
        check_output("first_product_mem0", data_out, 16'd2);
        for (int i = 1; i < 10; i++) apply_stimulus(1'b1, 1'b0, 8'd2);
        apply_stimulus(1'b0, 1'b0, 8'd9);
        apply_stimulus(1'b0, 1'b1, 8'd9);
        apply_stimulus(1'b0, 1'b0, 8'd9);
        apply_stimulus(1'b1, 1'b1, 8'h55);
        check_output("data_hold_after_gap", data_out, 16'd20);
        apply_stimulus(1'b1, 1'b0, 8'd2);
        check_output("resume_next_addr", data_out, 16'd22);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 1'b0, 8'd2);
        check_output("wrap_product", data_out, 16'd8);

        // Asynchronous reset while products are flowing, then the all-ones corner.
        apply_reset();
        load_words(0, 16, 8'hFF, 8'h00);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 8'hFF);
        check_output("max_product", data_out, 16'hFE01);

        // Partial load, compute attempt before lock-in, then resume loading at the held address.
        apply_reset();
        load_words(0, 8, 8'h10, 8'd3);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 8'(i + 5));
        apply_stimulus(1'b0, 1'b1, 8'hAA);
        check_output("partial_init_done", init_done, 1'b0);
        load_words(8, 8, 8'h10, 8'd3);
        check_output("resumed_init_done", init_done, 1'b1);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 8'(i + 1));

        // Three reset/load/compute rounds with random coefficients and operands.
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)));
            for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        end

        apply_stimulus(1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sram_mult_system.md
# sram_mult_system

Weight-stationary multiply block: a 16×8 SRAM is loaded with coefficients, and each streamed operand is multiplied by the coefficients in rotating address order. It is the processing-element wrapper of the SRAM 16×8 digital compute-in-memory example, between the stimulus/operand source and the result sink. The RTL module is named `sram_mult_system` and keeps the port names below.

## Interface
Parameters:
- DATA_WIDTH, 8: width of operands and stored words
- ADDR_COUNT, 16: number of SRAM words
- ADDR_WIDTH, 4: address width, equal to log2(ADDR_COUNT)
- MULT_WIDTH, 2*DATA_WIDTH: product width

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pe_ce  in  1  block enable; when low, the block does nothing.
- init_enable  in  1  high = load phase, low = compute phase.
- data_in  in  DATA_WIDTH  coefficient during load, operand during compute.
- data_out  out  MULT_WIDTH  registered product.
- init_done  out  1  high once all ADDR_COUNT words are loaded.
- valid_out  out  1  data_out holds a new product this cycle.

## Operation
- Reset sets wr_ptr=0, rd_ptr=0, init_done=0, valid_out=0, data_out=0. SRAM contents are not reset.
- Load cycle: pe_ce=1, init_enable=1, init_done=0.
  - Write mem[wr_ptr] <= data_in.
  - If wr_ptr==ADDR_COUNT-1, set init_done<=1 and wr_ptr<=0. Otherwise wr_ptr<=wr_ptr+1.
- Writes while init_done=1 are ignored; coefficients stay locked until reset.
- init_enable dropped before the last word: wr_ptr holds its value, and loading resumes at the same address when init_enable returns.
- Compute cycle: pe_ce=1, init_enable=0, init_done=1.
  - data_out <= data_in * mem[rd_ptr], unsigned, full MULT_WIDTH, no truncation.
  - valid_out <= 1.
  - rd_ptr increments and wraps from ADDR_COUNT-1 to 0.
- Any other cycle: valid_out <= 0, data_out holds its value, and pointers hold.
  - This covers pe_ce=0, compute requested before init_done, and init_enable=1 after init_done.
- The compute address sequence always starts at 0 after reset and continues across gaps in valid cycles. It is not re-aligned.

## Timing
- Load: a word is written on the edge where it is sampled.
- init_done rises on the edge that writes word ADDR_COUNT-1, i.e. the 16th qualifying load edge.
- Compute latency is 1 cycle: an operand sampled at edge N appears on data_out, with valid_out=1, after edge N.
- valid_out is a one-cycle-per-operand strobe. There is no backpressure.
- First compute edge after init_done uses mem[0], i.e. the first loaded word.
- Boundary cases:
  - rd_ptr wraps after 16 products.
  - Assertion of rst_n=0 takes effect immediately (asynchronous) during either phase.
  - After reset, the load sequence restarts at address 0 and the old contents are overwritten.

## Structure
- Shared package `sram_mult_pkg`: DATA_WIDTH, ADDR_COUNT, ADDR_WIDTH, MULT_WIDTH constants.
- One sub-module, `sram_16x8`:
  - parameterised register array;
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port (raddr, rdata).
- Top level holds the pointers, init_done flag, multiplier and output registers.

## Test plan
- Reset: hold rst_n=0 mid-cycle -> data_out=0, valid_out=0, init_done=0 immediately; no valid_out while init_enable=1.
- Load 1..16 to addr 0..15 with init_enable=1 for 16 edges -> init_done=1 after the 16th edge. Then stream operands 2,2,... -> outputs 2,4,...,32, then 2 again on the 17th (wrap).
- Load all 0xFF, operand 0xFF -> data_out=65025 (0xFE01) every cycle with valid_out=1.
- Drop pe_ce for 3 cycles mid-stream -> valid_out=0, data_out holds; the next product uses the next address in sequence.
- Load only 8 words, drop init_enable, then drive operands -> init_done=0, valid_out stays 0. Resume with 8 more words -> init_done=1.
- Three back-to-back reset/load/compute rounds with random data -> each round's 16 outputs equal operand × the coefficients loaded in that round, in address order.
